// File: rtl/count_event_conditioner.sv
// rtl/count_event_conditioner.sv - synchronise, debounce and prescale a raw event into CE pulses
// Optional GLITCH_CNT output enabled by COUNT_EVENT_CONDITIONER_GLITCH_CNT_EN.
module count_event_conditioner #(
  parameter int DB_CYCLES = 4,
  parameter int DIV       = 1
) (
  input  logic       C,
  input  logic       CLR,
  input  logic       EN,
  input  logic       D,
  output logic       CE,
  output logic       BUSY,
  output logic       GLITCH
`ifdef COUNT_EVENT_CONDITIONER_GLITCH_CNT_EN
  ,
  output logic [7:0] GLITCH_CNT
`endif
);

  localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [7:0]      DB_LAST  = 8'(DB_CYCLES - 1);
  localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0]   PRE_ONE  = PW'(1);

  typedef enum logic [1:0] {IDLE, QUAL, HOLD, REL} state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic          r_s1;
  logic          r_s2;
  logic          w_ds;
  logic [7:0]    r_db_cnt;
  logic [7:0]    w_db_next;
  logic [PW-1:0] r_pre_cnt;
  logic          w_accept;
  logic          w_glitch;
  logic          w_pre_wrap;

  assign w_ds       = r_s2;
  assign w_pre_wrap = (r_pre_cnt == PRE_LAST);

  always_ff @(posedge C or negedge CLR) begin
    if (!CLR) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= D;
      r_s2 <= r_s1;
    end
  end

  // A low on ds during qualification outranks an EN abort so short pulses are always reported.
  always_comb begin
    w_next_state = r_state;
    w_db_next    = r_db_cnt;
    w_accept     = 1'b0;
    w_glitch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (EN && w_ds) begin
          w_next_state = QUAL;
          w_db_next    = 8'd0;
        end
      end
      QUAL: begin
        if (!w_ds) begin
          w_next_state = IDLE;
          w_glitch     = 1'b1;
        end else if (!EN) begin
          w_next_state = IDLE;
        end else if (r_db_cnt == DB_LAST) begin
          w_next_state = HOLD;
          w_accept     = 1'b1;
        end else begin
          w_db_next = r_db_cnt + 8'd1;
        end
      end
      HOLD: begin
        if (!w_ds) begin
          w_next_state = REL;
          w_db_next    = 8'd0;
        end
      end
      REL: begin
        if (w_ds) begin
          w_next_state = HOLD;
        end else if (r_db_cnt == DB_LAST) begin
          w_next_state = IDLE;
        end else begin
          w_db_next = r_db_cnt + 8'd1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge C or negedge CLR) begin
    if (!CLR) begin
      r_state   <= IDLE;
      r_db_cnt  <= 8'd0;
      r_pre_cnt <= '0;
      CE        <= 1'b0;
      BUSY      <= 1'b0;
      GLITCH    <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_db_cnt <= w_db_next;
      BUSY     <= (w_next_state != IDLE);
      GLITCH   <= w_glitch;
      CE       <= w_accept && w_pre_wrap;
      if (w_accept) begin
        r_pre_cnt <= w_pre_wrap ? '0 : r_pre_cnt + PRE_ONE;
      end
    end
  end

`ifdef COUNT_EVENT_CONDITIONER_GLITCH_CNT_EN
  always_ff @(posedge C or negedge CLR) begin
    if (!CLR) begin
      GLITCH_CNT <= 8'd0;
    end else if (w_glitch && (GLITCH_CNT != 8'hFF)) begin
      GLITCH_CNT <= GLITCH_CNT + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_count_event_conditioner.sv
// tb/tb_count_event_conditioner.sv - scoreboard bench for count_event_conditioner (DIV=1 and DIV=3)
module tb_count_event_conditioner;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic en  = 1'b0;
  logic d   = 1'b0;
  logic ce1, busy1, gl1;
  logic ce3, busy3, gl3;
`ifdef COUNT_EVENT_CONDITIONER_GLITCH_CNT_EN
  logic [7:0] gcnt1, gcnt3;
`endif

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int acc3   = 0;
  int q1[$];
  int q3[$];
  int qg[$];
  int qg3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  count_event_conditioner #(.DB_CYCLES(4), .DIV(1)) u_dut1 (
    .C(clk), .CLR(clr), .EN(en), .D(d), .CE(ce1), .BUSY(busy1), .GLITCH(gl1)
`ifdef COUNT_EVENT_CONDITIONER_GLITCH_CNT_EN
    , .GLITCH_CNT(gcnt1)
`endif
  );

  count_event_conditioner #(.DB_CYCLES(4), .DIV(3)) u_dut3 (
    .C(clk), .CLR(clr), .EN(en), .D(d), .CE(ce3), .BUSY(busy3), .GLITCH(gl3)
`ifdef COUNT_EVENT_CONDITIONER_GLITCH_CNT_EN
    , .GLITCH_CNT(gcnt3)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic pop_chk(input string name, inout int q[$]);
    int e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected pulse at edge %0d: got pulse expected none", name, cyc);
    end else begin
      e = q.pop_front();
      if (e != cyc) begin
        errors++;
        $display("FAIL %s at edge %0d: got pulse expected at edge %0d", name, cyc, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (ce1) pop_chk("ce_div1", q1);
    if (ce3) pop_chk("ce_div3", q3);
    if (gl1) pop_chk("glitch_div1", qg);
    if (gl3) pop_chk("glitch_div3", qg3);
  end

  // An accepted press produces CE 7 edges after D rises; the DIV=3 unit fires on every third one.
  task automatic expect_accept(input int c0);
    q1.push_back(c0 + 7);
    if (acc3 == 2) q3.push_back(c0 + 7);
    acc3 = (acc3 + 1) % 3;
  endtask

  task automatic release_check(input int lo);
    repeat (6) @(negedge clk);
    chk("busy1_before_release_done", busy1, 1);
    chk("busy3_before_release_done", busy3, 1);
    @(negedge clk);
    chk("busy1_after_release", busy1, 0);
    chk("busy3_after_release", busy3, 0);
    repeat (lo - 7) @(negedge clk);
  endtask

  task automatic press(input int hi, input int lo, input bit drop_en);
    @(negedge clk);
    d = 1'b1;
    expect_accept(cyc);
    repeat (hi / 2) @(negedge clk);
    if (drop_en) en = 1'b0;
    repeat (hi - hi / 2) @(negedge clk);
    d = 1'b0;
    release_check(lo);
  endtask

  initial begin
    int c0;
    repeat (3) @(negedge clk);
    chk("reset_ce1", ce1, 0);
    chk("reset_busy1", busy1, 0);
    chk("reset_glitch1", gl1, 0);
    chk("reset_ce3", ce3, 0);
    chk("reset_busy3", busy3, 0);
    chk("reset_glitch3", gl3, 0);
    clr = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b1;

    press(20, 20, 1'b0);

    @(negedge clk);
    d = 1'b1;
    c0 = cyc;
    qg.push_back(c0 + 6);
    qg3.push_back(c0 + 6);
    repeat (3) @(negedge clk);
    d = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy1_after_glitch", busy1, 0);
    chk("busy3_after_glitch", busy3, 0);
`ifdef COUNT_EVENT_CONDITIONER_GLITCH_CNT_EN
    chk("glitch_cnt1", gcnt1, 1);
    chk("glitch_cnt3", gcnt3, 1);
`endif
    repeat (10) @(negedge clk);

    for (int i = 0; i < 5; i++) press(10, 10, 1'b0);

    @(negedge clk);
    d = 1'b1;
    expect_accept(cyc);
    repeat (12) @(negedge clk);
    d = 1'b0;
    repeat (2) @(negedge clk);
    d = 1'b1;
    @(negedge clk);
    d = 1'b0;
    release_check(20);
    press(10, 10, 1'b0);

    en = 1'b0;
    @(negedge clk);
    d = 1'b1;
    repeat (5) @(negedge clk);
    chk("busy1_en_low", busy1, 0);
    chk("busy3_en_low", busy3, 0);
    d = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;

    @(negedge clk);
    d = 1'b1;
    repeat (4) @(negedge clk);
    chk("busy1_in_qual", busy1, 1);
    en = 1'b0;
    @(negedge clk);
    chk("busy1_qual_abort", busy1, 0);
    chk("busy3_qual_abort", busy3, 0);
    d = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;

    press(20, 10, 1'b1);
    en = 1'b1;
    repeat (3) @(negedge clk);

    while (acc3 != 1) press(10, 10, 1'b0);
    @(negedge clk);
    d = 1'b1;
    repeat (4) @(negedge clk);
    chk("busy3_before_clr", busy3, 1);
    #2 clr = 1'b0;
    #1;
    chk("busy1_async_clr", busy1, 0);
    chk("busy3_async_clr", busy3, 0);
    chk("ce1_async_clr", ce1, 0);
    chk("ce3_async_clr", ce3, 0);
    @(negedge clk);
    d = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    acc3 = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) press(10, 10, 1'b0);

    repeat (10) @(negedge clk);
    chk("ce1_queue_drained", q1.size(), 0);
    chk("ce3_queue_drained", q3.size(), 0);
    chk("glitch_queue_drained", qg.size() + qg3.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
